// File: rtl/sm4_crypt_core_pkg.sv
// Shared SM4 constants: S-box, FK and CK tables, and the crypt-core FSM encoding.
// Used by key expansion and the crypt datapath.
package sm4_crypt_core_pkg;

    localparam int unsigned BLOCK_W  = 128;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ROUNDS   = 32;
    localparam int unsigned RIDX_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_ROUND    = 2'd2
    } crypt_state_e;

    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [31:0] CK [32] = '{
        32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
        32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
        32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
        32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
        32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
        32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
        32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
        32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
    };

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // Non-linear tau: S-box applied to each byte of a word.
    function automatic logic [31:0] sbox_word(input logic [31:0] w);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX[w[8*i +: 8]];
        end
        return r;
    endfunction

endpackage

// File: rtl/sm4_crypt_core_round.sv
// One combinational SM4 cipher round: X' = {X1, X2, X3, X0 ^ L(tau(X1^X2^X3^rk))}.
module sm4_crypt_core_round
    import sm4_crypt_core_pkg::*;
(
    input  logic [BLOCK_W-1:0] x_i,
    input  logic [WORD_W-1:0]  rk_i,
    output logic [BLOCK_W-1:0] x_o
);

    logic [WORD_W-1:0] t;
    logic [WORD_W-1:0] b;
    logic [WORD_W-1:0] l;

    always_comb begin
        t   = x_i[95:64] ^ x_i[63:32] ^ x_i[31:0] ^ rk_i;
        b   = sbox_word(t);
        // Encryption linear transform L (not key expansion's L').
        l   = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
                ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
        x_o = {x_i[95:0], x_i[127:96] ^ l};
    end

endmodule

// File: rtl/sm4_crypt_core.sv
// Iterative SM4 encrypt/decrypt core: 1 prefetch cycle, 32 round cycles,
// round keys read from a registered RAM one cycle ahead of use.
module sm4_crypt_core
    import sm4_crypt_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 key_valid,
    input  logic                 start,
    input  logic                 mode,
    input  logic [BLOCK_W-1:0]   din,
    output logic [RIDX_W-1:0]    ikey_cnt,
    input  logic [WORD_W-1:0]    ikey,
    output logic [BLOCK_W-1:0]   dout,
    output logic                 done,
    output logic                 busy
);

    localparam logic [RIDX_W-1:0] R_LAST = RIDX_W'(ROUNDS - 1);

    crypt_state_e       state_q, state_d;
    logic               mode_q, mode_d;
    logic [BLOCK_W-1:0] x_q, x_d;
    logic [RIDX_W-1:0]  r_q, r_d;
    logic [RIDX_W-1:0]  ikey_cnt_q, ikey_cnt_d;
    logic [BLOCK_W-1:0] dout_q, dout_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [BLOCK_W-1:0] x_next;

    function automatic logic [RIDX_W-1:0] key_idx(input logic dec, input logic [RIDX_W-1:0] r);
        return dec ? RIDX_W'(R_LAST - r) : r;
    endfunction

    sm4_crypt_core_round u_round (
        .x_i  (x_q),
        .rk_i (ikey),
        .x_o  (x_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= 1'b0;
            x_q        <= '0;
            r_q        <= '0;
            ikey_cnt_q <= '0;
            dout_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            x_q        <= x_d;
            r_q        <= r_d;
            ikey_cnt_q <= ikey_cnt_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; ikey_cnt is registered so it is computed one cycle early.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        x_d        = x_q;
        r_d        = r_q;
        ikey_cnt_d = ikey_cnt_q;
        dout_d     = dout_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                ikey_cnt_d = '0;
                if (start && key_valid) begin
                    state_d    = ST_PREFETCH;
                    mode_d     = mode;
                    x_d        = din;
                    r_d        = '0;
                    ikey_cnt_d = key_idx(mode, '0);
                    busy_d     = 1'b1;
                end
            end
            ST_PREFETCH: begin
                state_d    = ST_ROUND;
                ikey_cnt_d = key_idx(mode_q, RIDX_W'(1));
            end
            ST_ROUND: begin
                x_d = x_next;
                r_d = RIDX_W'(r_q + RIDX_W'(1));
                if (r_q == R_LAST) begin
                    state_d    = ST_IDLE;
                    ikey_cnt_d = '0;
                    dout_d     = {x_next[31:0], x_next[63:32], x_next[95:64], x_next[127:96]};
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                end else if (r_q >= RIDX_W'(ROUNDS - 2)) begin
                    ikey_cnt_d = '0;
                end else begin
                    ikey_cnt_d = key_idx(mode_q, RIDX_W'(r_q + RIDX_W'(2)));
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ikey_cnt = ikey_cnt_q;
    assign dout     = dout_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule
